// File: rtl/hr_bridge_sched_pkg.sv
// Shared definitions for the hierarchical-ring bridge transfer-FIFO scheduler:
// default widths/sizes, the scheduler FSM encoding and a small width helper.
package hr_bridge_sched_pkg;

  // Width of one flit on the ring (control_w).
  localparam int CONTROL_W = 144;

  // Default number of ingress ports, FIFO depth and starvation limit.
  localparam int NREQ_DEF       = 4;
  localparam int DEPTH_DEF      = 8;
  localparam int STARVE_LIM_DEF = 15;

  // Scheduler FSM: plain round-robin, or exclusive priority for one port.
  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_PRIO = 1'b1
  } sched_state_t;

  // Index width for n items; never returns zero so single-port builds still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hr_bridge_sched_rr_arbiter.sv
// Round-robin arbiter: scans req from ptr upwards (mod NREQ) and grants the first
// port that is both requesting and enabled by mask. Purely combinational.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [NREQ-1:0]  mask,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  // First eligible requester at or after ptr wins; grant is one-hot or zero.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!valid && req[j] && mask[j]) begin
        grant[j] = 1'b1;
        idx      = j[PTR_W-1:0];
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hr_bridge_sched.sv
// Enqueue/dequeue scheduler for one local-ring transfer FIFO of the ring bridge.
// Arbitrates the global-ring ingress ports round-robin, escalates a starved port
// to exclusive priority, tracks FIFO occupancy and pops when the local ring has
// a free slot.
//
// Handshake: an ingress port offers a flit by holding req_i[i]; it is accepted
// in a cycle where grant_o[i] is high, and must keep req_i[i] and its flit
// stable until then. enQ_o/fifo_data_o are the FIFO write side in the same
// cycle; deQ_o pops one flit whenever occupancy is nonzero and slot_free_i is
// high. No grant is ever issued while the FIFO is full, even when it pops in
// the same cycle.
module hr_bridge_sched
  import hr_bridge_sched_pkg::*;
#(
  parameter int FLIT_W     = CONTROL_W,
  parameter int NREQ       = NREQ_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_i,
  input  logic [NREQ*FLIT_W-1:0]     flit_i,
  input  logic                       slot_free_i,
  output logic [NREQ-1:0]            grant_o,
  output logic                       enQ_o,
  output logic [FLIT_W-1:0]          fifo_data_o,
  output logic                       deQ_o,
  output logic                       bfull_o,
  output logic [$clog2(DEPTH+1)-1:0] occ_o,
  output logic                       prio_o
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = idx_width(NREQ);
  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] LIM_V   = CNT_W'(STARVE_LIM);
  localparam logic [PTR_W-1:0] LAST_V  = PTR_W'(NREQ - 1);

  // Registered scheduler state.
  logic [OCC_W-1:0] occ;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] wait_cnt [NREQ];
  sched_state_t     state;
  logic [PTR_W-1:0] prio_idx;

  // Combinational helpers.
  logic             can_enq;
  logic [NREQ-1:0]  arb_req;
  logic [NREQ-1:0]  arb_mask;
  logic [NREQ-1:0]  arb_grant;
  logic [PTR_W-1:0] arb_idx;
  logic             arb_valid;
  logic [CNT_W-1:0] wait_nxt [NREQ];
  logic             sat_any;
  logic [PTR_W-1:0] sat_idx;
  logic             prio_done;

  // A flit may only be written while the FIFO has room; reset masks everything.
  assign can_enq = (occ != DEPTH_V);
  assign arb_req = (rst || !can_enq) ? '0 : req_i;

  // In PRIO only the escalated port may win; in ARB every port is eligible.
  always_comb begin
    arb_mask = '1;
    if (state == ST_PRIO) begin
      arb_mask           = '0;
      arb_mask[prio_idx] = 1'b1;
    end
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (arb_req),
    .ptr   (ptr),
    .mask  (arb_mask),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // FIFO write side and status outputs; all forced low while in reset.
  assign grant_o     = arb_grant;
  assign enQ_o       = arb_valid;
  assign fifo_data_o = arb_valid ? flit_i[arb_idx*FLIT_W +: FLIT_W] : '0;
  assign deQ_o       = !rst && (occ != '0) && slot_free_i;
  assign bfull_o     = !rst && (occ == DEPTH_V);
  assign occ_o       = rst ? '0 : occ;
  assign prio_o      = !rst && (state == ST_PRIO);

  // Next wait counts: count blocked cycles, clear on grant or withdrawn request.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      wait_nxt[i] = wait_cnt[i];
      if (!req_i[i] || grant_o[i]) begin
        wait_nxt[i] = '0;
      end else if (wait_cnt[i] != LIM_V) begin
        wait_nxt[i] = wait_cnt[i] + 1'b1;
      end
    end
  end

  // Lowest-indexed port whose wait count is saturated after this edge.
  always_comb begin
    sat_any = 1'b0;
    sat_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (wait_nxt[i] == LIM_V) begin
        sat_any = 1'b1;
        sat_idx = PTR_W'(i);
      end
    end
  end

  // The escalated port is finished once served or once it stops asking.
  assign prio_done = grant_o[prio_idx] || !req_i[prio_idx];

  // Occupancy, round-robin pointer, wait counters and ARB/PRIO FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= '0;
      ptr      <= '0;
      state    <= ST_ARB;
      prio_idx <= '0;
      for (int i = 0; i < NREQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      // enQ only when not full and deQ only when not empty, so no wrap.
      case ({enQ_o, deQ_o})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      // The pointer only advances on round-robin grants, never in PRIO.
      if (state == ST_ARB && enQ_o) begin
        ptr <= (arb_idx == LAST_V) ? '0 : arb_idx + 1'b1;
      end

      for (int i = 0; i < NREQ; i++) begin
        wait_cnt[i] <= wait_nxt[i];
      end

      case (state)
        ST_ARB: begin
          if (sat_any) begin
            state    <= ST_PRIO;
            prio_idx <= sat_idx;
          end
        end
        ST_PRIO: begin
          if (prio_done) begin
            if (sat_any) begin
              state    <= ST_PRIO;
              prio_idx <= sat_idx;
            end else begin
              state    <= ST_ARB;
            end
          end
        end
        default: begin
          state <= ST_ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hr_bridge_sched.sv
// Directed bench for hr_bridge_sched: a vector table for single-cycle behaviour
// plus hand-written sequences for starvation escalation and reset in PRIO.
module tb_hr_bridge_sched;

  localparam int FLIT_W = 144;
  localparam int NREQ   = 4;
  localparam int DEPTH  = 8;
  localparam int OCC_W  = 4;

  // Clock / reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT connections.
  logic [NREQ-1:0]        req_i = '0;
  logic [NREQ*FLIT_W-1:0] flit_i = '0;
  logic                   slot_free_i = 1'b0;
  logic [NREQ-1:0]        grant_o;
  logic                   enQ_o;
  logic [FLIT_W-1:0]      fifo_data_o;
  logic                   deQ_o;
  logic                   bfull_o;
  logic [OCC_W-1:0]       occ_o;
  logic                   prio_o;

  hr_bridge_sched #(
    .FLIT_W     (FLIT_W),
    .NREQ       (NREQ),
    .DEPTH      (DEPTH),
    .STARVE_LIM (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .flit_i      (flit_i),
    .slot_free_i (slot_free_i),
    .grant_o     (grant_o),
    .enQ_o       (enQ_o),
    .fifo_data_o (fifo_data_o),
    .deQ_o       (deQ_o),
    .bfull_o     (bfull_o),
    .occ_o       (occ_o),
    .prio_o      (prio_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Flits currently offered by each port, and the expected FIFO write stream.
  logic [FLIT_W-1:0] flits [NREQ];
  logic [FLIT_W-1:0] exp_q [$];

  typedef struct {
    logic [3:0] req;
    logic       sf;
    logic [3:0] grant;
    logic       deq;
    logic [3:0] occ;
    logic       full;
    logic       prio;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs with fresh flits, check outputs mid-cycle, then clock.
  task automatic run(input string name, input logic [3:0] req, input logic sf,
                     input logic [3:0] eg, input logic ed, input logic [3:0] eo,
                     input logic ef, input logic ep);
    logic [159:0]      r;
    logic [FLIT_W-1:0] ed_data;
    for (int i = 0; i < NREQ; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      flits[i] = r[FLIT_W-1:0];
      flit_i[i*FLIT_W +: FLIT_W] = flits[i];
    end
    req_i       = req;
    slot_free_i = sf;
    ed_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (eg[i]) ed_data = flits[i];
    end
    if (eg != 4'b0000) exp_q.push_back(ed_data);
    #3;
    chk({name, ".grant"}, 160'(grant_o), 160'(eg));
    chk({name, ".enq"},   160'(enQ_o),   160'(eg != 4'b0000));
    chk({name, ".data"},  160'(fifo_data_o), 160'(ed_data));
    chk({name, ".deq"},   160'(deQ_o),   160'(ed));
    chk({name, ".occ"},   160'(occ_o),   160'(eo));
    chk({name, ".bfull"}, 160'(bfull_o), 160'(ef));
    chk({name, ".prio"},  160'(prio_o),  160'(ep));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every FIFO write must match the next expected flit.
  always @(negedge clk) begin
    if (enQ_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb.write: got unexpected write %0h expected none", fifo_data_o);
      end else begin
        logic [FLIT_W-1:0] e;
        e = exp_q.pop_front();
        if (fifo_data_o !== e) begin
          n_fail++;
          $display("FAIL sb.write: got %0h expected %0h", fifo_data_o, e);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Table: {req, slot_free, grant, deq, occ before edge, bfull, prio}.
    vecs[0]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0101, 1'b0, 4'b0100, 1'b0, 4'd1, 1'b0, 1'b0};
    vecs[2]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 4'd2, 1'b0, 1'b0};
    vecs[3]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 4'd3, 1'b0, 1'b0};
    vecs[4]  = '{4'b0010, 1'b0, 4'b0010, 1'b0, 4'd3, 1'b0, 1'b0};
    vecs[5]  = '{4'b1000, 1'b0, 4'b1000, 1'b0, 4'd4, 1'b0, 1'b0};
    vecs[6]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 4'd5, 1'b0, 1'b0};
    vecs[7]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 4'd6, 1'b0, 1'b0};
    vecs[8]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 4'd7, 1'b0, 1'b0};
    vecs[9]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 4'd8, 1'b1, 1'b0};
    vecs[10] = '{4'b0001, 1'b1, 4'b0000, 1'b1, 4'd8, 1'b1, 1'b0};
    vecs[11] = '{4'b0001, 1'b0, 4'b0001, 1'b0, 4'd7, 1'b0, 1'b0};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'd8, 1'b1, 1'b0};
    for (int k = 0; k < 7; k++) begin
      vecs[13+k] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'(7 - k), 1'b0, 1'b0};
    end
    vecs[20] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0};

    // Reset: outputs held low even with requests and a free slot.
    rst = 1'b1;
    run("rst0", 4'b1111, 1'b1, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
    run("rst1", 4'b1111, 1'b1, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Table-driven single-cycle behaviour: RR order, fill, no full bypass, drain.
    for (int i = 0; i < 21; i++) begin
      run($sformatf("vec%0d", i), vecs[i].req, vecs[i].sf, vecs[i].grant,
          vecs[i].deq, vecs[i].occ, vecs[i].full, vecs[i].prio);
    end

    // Fill to full from port 0 only (occ 0..7 before each edge, ptr ends at 1).
    for (int k = 0; k < 8; k++) begin
      run($sformatf("fill%0d", k), 4'b0001, 1'b0, 4'b0001, 1'b0, 4'(k), 1'b0, 1'b0);
    end
    // All ports blocked by a full FIFO: escalation happens at the 15th edge.
    for (int k = 0; k < 15; k++) begin
      run($sformatf("hold%0d", k), 4'b1111, 1'b0, 4'b0000, 1'b0, 4'd8, 1'b1, 1'b0);
    end
    // Drain one per cycle: PRIO serves 0,1,2,3 in turn, then ARB resumes at ptr 1.
    run("drain1", 4'b1111, 1'b1, 4'b0000, 1'b1, 4'd8, 1'b1, 1'b1);
    run("drain2", 4'b1111, 1'b1, 4'b0001, 1'b1, 4'd7, 1'b0, 1'b1);
    run("drain3", 4'b1111, 1'b1, 4'b0010, 1'b1, 4'd7, 1'b0, 1'b1);
    run("drain4", 4'b1111, 1'b1, 4'b0100, 1'b1, 4'd7, 1'b0, 1'b1);
    run("drain5", 4'b1111, 1'b1, 4'b1000, 1'b1, 4'd7, 1'b0, 1'b1);
    run("drain6", 4'b1111, 1'b1, 4'b0010, 1'b1, 4'd7, 1'b0, 1'b0);

    // Re-enter PRIO with a full FIFO, then reset in the middle of it.
    run("refill", 4'b0001, 1'b0, 4'b0001, 1'b0, 4'd7, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      run($sformatf("rehold%0d", k), 4'b1111, 1'b0, 4'b0000, 1'b0, 4'd8, 1'b1, 1'b0);
    end
    run("inprio", 4'b1111, 1'b0, 4'b0000, 1'b0, 4'd8, 1'b1, 1'b1);
    rst = 1'b1;
    run("rst_mid", 4'b1111, 1'b1, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    run("post_rst", 4'b1000, 1'b0, 4'b1000, 1'b0, 4'd0, 1'b0, 1'b0);
    run("post_rr",  4'b1111, 1'b0, 4'b0001, 1'b0, 4'd1, 1'b0, 1'b0);
    run("idle",     4'b0000, 1'b0, 4'b0000, 1'b0, 4'd2, 1'b0, 1'b0);

    chk("sb.drained", 160'(exp_q.size()), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
